chu_pdm_audio_core: RTL



---
 rtl/chu_pdm_audio_core.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/chu_pdm_audio_core.sv
// FPro MMIO slot: PCM sample FIFO feeding a PDM modulator.
// Define PDM_SECOND_ORDER_EN for a second-order modulator.
module chu_pdm_audio_core #(
    parameter int W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        pdm_out,
    output logic [15:0] pcm_out
);

    logic [15:0]  mem [0:2**W-1];
    logic [W-1:0] wr_ptr, rd_ptr;
    logic [W:0]   count;
    logic         en, overrun, underrun;
    logic [15:0]  pdm_div, div_cnt;
    logic [7:0]   osr, osr_cnt;
    logic         wr_en, wr_fifo, wr_ctrl, wr_div, wr_osr, wr_clr;
    logic         flush, empty, full, push_ok, pop;
    logic         pdm_tick, smp_tick;
    logic         unused_ok;

    assign wr_en   = cs & write;
    assign wr_fifo = wr_en & (addr == 5'd0);
    assign wr_ctrl = wr_en & (addr == 5'd1);
    assign wr_div  = wr_en & (addr == 5'd2);
    assign wr_osr  = wr_en & (addr == 5'd3);
    assign wr_clr  = wr_en & (addr == 5'd4);
    assign flush   = wr_ctrl & wr_data[1];

    assign empty   = (count == '0);
    assign full    = count[W];
    assign pdm_tick = en & (div_cnt == pdm_div);
    assign smp_tick = pdm_tick & (osr_cnt == osr);
    assign pop     = smp_tick & ~empty;
    assign push_ok = wr_fifo & (~full | pop);

    assign unused_ok = ^{read, wr_data[31:16]};

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            en      <= 1'b0;
            pdm_div <= 16'd49;
            osr     <= 8'd63;
        end else begin
            if (wr_ctrl) en <= wr_data[0];
            if (wr_div) pdm_div <= wr_data[15:0];
            if (wr_osr) osr <= wr_data[7:0];
        end
    end

    // FIFO storage, written only on accepted pushes
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data[15:0];
    end

    // FIFO pointers and occupancy; flush empties without touching data path
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + {{(W-1){1'b0}}, 1'b1};
            if (pop) rd_ptr <= rd_ptr + {{(W-1){1'b0}}, 1'b1};
            case ({push_ok, pop})
                2'b10:   count <= count + {{W{1'b0}}, 1'b1};
                2'b01:   count <= count - {{W{1'b0}}, 1'b1};
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a new event wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            overrun  <= (overrun & ~wr_clr) | (wr_fifo & full & ~pop);
            underrun <= (underrun & ~wr_clr) | (smp_tick & empty);
        end
    end

    // Tick counters; a counter above a freshly lowered limit wraps naturally
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt <= '0;
            osr_cnt <= '0;
        end else begin
            div_cnt <= pdm_tick ? 16'd0 : div_cnt + 16'd1;
            if (pdm_tick)
                osr_cnt <= (osr_cnt == osr) ? 8'd0 : osr_cnt + 8'd1;
        end
    end

    // Sample register loaded from the FIFO head on each sample tick
    always_ff @(posedge clk) begin
        if (rst || !en) pcm_out <= '0;
        else if (pop) pcm_out <= mem[rd_ptr];
    end

`ifdef PDM_SECOND_ORDER_EN
    logic signed [23:0] i1, i2, i1_n, i2_n;
    logic signed [25:0] y, s1, s2;

    function automatic logic signed [23:0] sat24(input logic signed [25:0] v);
        if (v > 26'sd8388607) return 24'sh7fffff;
        else if (v < -26'sd8388608) return 24'sh800000;
        else return v[23:0];
    endfunction

    assign y    = pdm_out ? 26'sd32767 : -26'sd32768;
    assign s1   = $signed({{2{i1[23]}}, i1})
                + $signed({{10{pcm_out[15]}}, pcm_out}) - y;
    assign i1_n = sat24(s1);
    assign s2   = $signed({{2{i2[23]}}, i2})
                + $signed({{2{i1_n[23]}}, i1_n}) - y;
    assign i2_n = sat24(s2);

    // Second-order modulator: two saturating integrators, sign decides bit
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            i1      <= '0;
            i2      <= '0;
            pdm_out <= 1'b0;
        end else if (pdm_tick) begin
            i1      <= i1_n;
            i2      <= i2_n;
            pdm_out <= ~i2_n[23];
        end
    end
`else
    logic [15:0] acc;
    logic [16:0] sum;

    assign sum = {1'b0, acc} + {1'b0, pcm_out ^ 16'h8000};

    // First-order modulator: accumulator carry is the output bit
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            acc     <= '0;
            pdm_out <= 1'b0;
        end else if (pdm_tick) begin
            acc     <= sum[15:0];
            pdm_out <= sum[16];
        end
    end
`endif

    // Register read mux, registered state only
    always_comb begin
        rd_data = '0;
        case (addr)
            5'd0: begin
                rd_data[8 +: W+1] = count;
                rd_data[3:0] = {overrun, underrun, full, empty};
            end
            5'd1: rd_data[0] = en;
            5'd2: rd_data[15:0] = pdm_div;
            5'd3: rd_data[7:0] = osr;
            default: rd_data = '0;
        endcase
    end

endmodule
